idec_stage: RTL and testbench

- Parametrised, pipelined instruction-decode stage that sits between fetch and execute.
- Buffers fetched instructions in a DEPTH-entry queue and decodes the head entry into a registered decoded-op bundle.
- Handshakes valid/ready on both sides and supports a branch flush.
- Stalls issue on a load-use hazard for LOAD_LAT cycles, which the previous combinational decoder could not do.

---
 rtl/idec_stage.sv | 170 +++++++++++++++++
 tb/tb_idec_stage.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/idec_stage.sv
// Instruction-decode stage: DEPTH-entry fetch queue feeding a registered decoded-op bundle,
// with branch flush and a load-use interlock that holds dependent consumers for LOAD_LAT cycles.
module idec_stage #(
  parameter int DATA_W   = 32,
  parameter int REG_AW   = 4,
  parameter int DEPTH    = 4,
  parameter int LOAD_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     fetch_valid,
  input  logic [DATA_W-1:0]        fetch_instr,
  input  logic [DATA_W-1:0]        fetch_pc,
  output logic                     fetch_ready,
  output logic                     dec_valid,
  input  logic                     dec_ready,
  output logic [DATA_W-1:0]        dec_pc,
  output logic [REG_AW-1:0]        dec_rn,
  output logic [REG_AW-1:0]        dec_rd,
  output logic [REG_AW-1:0]        dec_rm,
  output logic [3:0]               dec_alu_op,
  output logic                     dec_set_flags,
  output logic                     dec_reg_we,
  output logic                     dec_mem_we,
  output logic                     dec_is_load,
  output logic                     dec_ib,
  output logic                     dec_bl,
  output logic [DATA_W-1:0]        dec_bv,
  output logic                     dec_uses_rm,
  output logic [$clog2(DEPTH):0]   q_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int LW = (LOAD_LAT > 1) ? $clog2(LOAD_LAT + 1) : 1;

  typedef struct packed {
    logic [DATA_W-1:0] pc;
    logic [REG_AW-1:0] rn;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rm;
    logic [3:0]        alu_op;
    logic              set_flags;
    logic              reg_we;
    logic              mem_we;
    logic              is_load;
    logic              ib;
    logic              bl;
    logic [DATA_W-1:0] bv;
    logic              uses_rm;
  } dec_t;

  // Handshake: a transfer happens on a side exactly when valid and ready are both high at
  // the rising edge; the producer holds its payload stable until that edge.
  logic [DATA_W-1:0] r_q_instr [DEPTH];
  logic [DATA_W-1:0] r_q_pc    [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              r_dec_valid;
  dec_t              r_dec;
  logic [LW-1:0]     r_hz_cnt;
  logic [REG_AW-1:0] r_ld_rd;

  logic [DATA_W-1:0] w_instr;
  logic              w_data;
  logic              w_ldstr;
  logic              w_br;
  dec_t              w_dec;
  logic              w_push;
  logic              w_load;
  logic              w_issue_load;
  logic              w_blocked;

  always_comb begin
    w_instr = r_q_instr[r_rd_ptr];
    w_data  = (w_instr[27:26] == 2'b00);
    w_ldstr = (w_instr[27:26] == 2'b01);
    w_br    = (w_instr[27:25] == 3'b101);
    w_dec           = '0;
    w_dec.pc        = r_q_pc[r_rd_ptr];
    w_dec.rn        = REG_AW'(w_instr[19:16]);
    w_dec.rd        = (w_br && w_instr[24]) ? REG_AW'(14) : REG_AW'(w_instr[15:12]);
    w_dec.rm        = REG_AW'(w_instr[3:0]);
    w_dec.alu_op    = w_instr[24:21];
    w_dec.set_flags = w_instr[20] & ~w_br;
    w_dec.reg_we    = w_data | (w_ldstr & w_instr[20]) | (w_br & w_instr[24]);
    w_dec.mem_we    = w_ldstr & ~w_instr[20];
    w_dec.is_load   = w_ldstr & w_instr[20];
    w_dec.ib        = w_br;
    w_dec.bl        = w_br & w_instr[24];
    w_dec.bv        = {{(DATA_W-26){w_instr[23]}}, w_instr[23:0], 2'b00};
    w_dec.uses_rm   = (w_data & ~w_instr[25]) | (w_ldstr & w_instr[25]);
  end

  function automatic logic reads_reg(input dec_t d, input logic [REG_AW-1:0] r);
    return (~d.ib & (d.rn == r)) | (d.uses_rm & (d.rm == r)) | (d.mem_we & (d.rd == r));
  endfunction

  // The issue cycle of a load counts as the first held cycle, so the stored counter only
  // covers the remaining LOAD_LAT-1 cycles.
  assign w_issue_load = (LOAD_LAT != 0) && r_dec_valid && dec_ready && r_dec.is_load;
  assign w_blocked    = (w_issue_load && reads_reg(w_dec, r_dec.rd)) ||
                        ((r_hz_cnt != '0) && reads_reg(w_dec, r_ld_rd));

  assign fetch_ready = (r_count < CW'(DEPTH)) & ~rst;
  assign w_push      = fetch_valid & fetch_ready;
  assign w_load      = (r_count != '0) & (~r_dec_valid | dec_ready) & ~w_blocked;

  always_ff @(posedge clk) begin
    if (!rst && !flush && w_push) begin
      r_q_instr[r_wr_ptr] <= fetch_instr;
      r_q_pc[r_wr_ptr]    <= fetch_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_dec_valid <= 1'b0;
      r_dec       <= '0;
      r_hz_cnt    <= '0;
      r_ld_rd     <= '0;
    end else if (flush) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_dec_valid <= 1'b0;
      r_hz_cnt    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_load) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_load);

      if (w_load) begin
        r_dec       <= w_dec;
        r_dec_valid <= 1'b1;
      end else if (dec_ready) begin
        r_dec_valid <= 1'b0;
      end

      if (w_issue_load) begin
        r_ld_rd  <= r_dec.rd;
        r_hz_cnt <= (LOAD_LAT > 1) ? LW'(LOAD_LAT - 1) : '0;
      end else if (r_hz_cnt != '0) begin
        r_hz_cnt <= r_hz_cnt - LW'(1);
      end
    end
  end

  assign q_count       = r_count;
  assign dec_valid     = r_dec_valid;
  assign dec_pc        = r_dec.pc;
  assign dec_rn        = r_dec.rn;
  assign dec_rd        = r_dec.rd;
  assign dec_rm        = r_dec.rm;
  assign dec_alu_op    = r_dec.alu_op;
  assign dec_set_flags = r_dec.set_flags;
  assign dec_reg_we    = r_dec.reg_we;
  assign dec_mem_we    = r_dec.mem_we;
  assign dec_is_load   = r_dec.is_load;
  assign dec_ib        = r_dec.ib;
  assign dec_bl        = r_dec.bl;
  assign dec_bv        = r_dec.bv;
  assign dec_uses_rm   = r_dec.uses_rm;

endmodule

// File: tb/tb_idec_stage.sv
// Directed bench for idec_stage: decode fields, backpressure, branch decode, load-use
// interlock, flush and mid-stream reset, each scenario checked inline against hand values.
module tb_idec_stage;
  localparam int DATA_W = 32;
  localparam int REG_AW = 4;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst, flush, fetch_valid, fetch_ready, dec_valid, dec_ready;
  logic [DATA_W-1:0] fetch_instr, fetch_pc, dec_pc, dec_bv;
  logic [REG_AW-1:0] dec_rn, dec_rd, dec_rm;
  logic [3:0]        dec_alu_op;
  logic              dec_set_flags, dec_reg_we, dec_mem_we, dec_is_load, dec_ib, dec_bl, dec_uses_rm;
  logic [$clog2(DEPTH):0] q_count;

  int n_vec = 0;
  int n_err = 0;

  idec_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW), .DEPTH(DEPTH), .LOAD_LAT(1)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .fetch_valid(fetch_valid), .fetch_instr(fetch_instr), .fetch_pc(fetch_pc), .fetch_ready(fetch_ready),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_pc(dec_pc),
    .dec_rn(dec_rn), .dec_rd(dec_rd), .dec_rm(dec_rm), .dec_alu_op(dec_alu_op),
    .dec_set_flags(dec_set_flags), .dec_reg_we(dec_reg_we), .dec_mem_we(dec_mem_we),
    .dec_is_load(dec_is_load), .dec_ib(dec_ib), .dec_bl(dec_bl), .dec_bv(dec_bv),
    .dec_uses_rm(dec_uses_rm), .q_count(q_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] instr, input logic [31:0] pc);
    fetch_valid = 1'b1;
    fetch_instr = instr;
    fetch_pc    = pc;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; fetch_valid = 1'b0; fetch_instr = '0; fetch_pc = '0; dec_ready = 1'b0;
    tick(); tick();
    n_vec++; if (dec_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b exp 0", dec_valid); end
    n_vec++; if (q_count !== 3'd0) begin n_err++; $display("FAIL rst_count got %0d exp 0", q_count); end
    n_vec++; if (fetch_ready !== 1'b0) begin n_err++; $display("FAIL rst_fready got %b exp 0", fetch_ready); end
    n_vec++; if (dec_pc !== 32'h0 || dec_rd !== 4'h0) begin n_err++; $display("FAIL rst_fields got pc %h rd %0d exp 0", dec_pc, dec_rd); end
    rst = 1'b0;
    #1;
    n_vec++; if (fetch_ready !== 1'b1) begin n_err++; $display("FAIL rel_fready got %b exp 1", fetch_ready); end
  endtask

  task automatic test_data();
    dec_ready = 1'b1;
    push(32'hE0812003, 32'h100);
    tick();
    fetch_valid = 1'b0;
    n_vec++; if (dec_valid !== 1'b0 || q_count !== 3'd1) begin n_err++; $display("FAIL data_lat got v %b cnt %0d exp 0/1", dec_valid, q_count); end
    tick();
    n_vec++; if (dec_valid !== 1'b1 || dec_pc !== 32'h100) begin n_err++; $display("FAIL data_valid got v %b pc %h exp 1/100", dec_valid, dec_pc); end
    n_vec++; if ({dec_rn, dec_rd, dec_rm, dec_alu_op} !== {4'd1, 4'd2, 4'd3, 4'd4}) begin
      n_err++; $display("FAIL data_regs got rn %0d rd %0d rm %0d op %0d exp 1 2 3 4", dec_rn, dec_rd, dec_rm, dec_alu_op); end
    n_vec++; if ({dec_reg_we, dec_mem_we, dec_uses_rm, dec_is_load, dec_ib} !== 5'b10100) begin
      n_err++; $display("FAIL data_ctl got %b exp 10100", {dec_reg_we, dec_mem_we, dec_uses_rm, dec_is_load, dec_ib}); end
    tick();
    n_vec++; if (dec_valid !== 1'b0) begin n_err++; $display("FAIL data_drain got %b exp 0", dec_valid); end
  endtask

  task automatic test_full();
    dec_ready = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      push(32'hE0800000 | (i << 12), 32'h200 + 4 * i);
      tick();
    end
    push(32'hE0807000, 32'h300);
    n_vec++; if (q_count !== 3'd4 || fetch_ready !== 1'b0) begin n_err++; $display("FAIL full_cnt got %0d fr %b exp 4/0", q_count, fetch_ready); end
    tick(); tick();
    n_vec++; if (q_count !== 3'd4 || dec_valid !== 1'b1 || dec_pc !== 32'h200) begin
      n_err++; $display("FAIL full_hold got cnt %0d v %b pc %h exp 4/1/200", q_count, dec_valid, dec_pc); end
    dec_ready = 1'b1;
    tick();
    fetch_valid = 1'b0;
    n_vec++; if (q_count !== 3'd3 || dec_pc !== 32'h204 || dec_rd !== 4'd1) begin
      n_err++; $display("FAIL full_pop got cnt %0d pc %h rd %0d exp 3/204/1", q_count, dec_pc, dec_rd); end
    for (int j = 2; j <= DEPTH; j++) begin
      tick();
      n_vec++; if (dec_valid !== 1'b1 || dec_pc !== 32'h200 + 4 * j || dec_rd !== 4'(j)) begin
        n_err++; $display("FAIL full_order got v %b pc %h rd %0d exp pc %h", dec_valid, dec_pc, dec_rd, 32'h200 + 4 * j); end
    end
    tick();
    n_vec++; if (dec_valid !== 1'b0 || q_count !== 3'd0) begin n_err++; $display("FAIL full_empty got v %b cnt %0d exp 0/0", dec_valid, q_count); end
  endtask

  task automatic test_branch();
    dec_ready = 1'b1;
    push(32'hEBFFFFFE, 32'h400);
    tick();
    fetch_valid = 1'b0;
    tick();
    n_vec++; if (dec_valid !== 1'b1 || dec_bl !== 1'b1 || dec_ib !== 1'b1) begin
      n_err++; $display("FAIL bl_flags got v %b bl %b ib %b exp 1 1 1", dec_valid, dec_bl, dec_ib); end
    n_vec++; if (dec_rd !== 4'd14 || dec_set_flags !== 1'b0 || dec_reg_we !== 1'b1) begin
      n_err++; $display("FAIL bl_rd got rd %0d s %b we %b exp 14 0 1", dec_rd, dec_set_flags, dec_reg_we); end
    n_vec++; if (dec_bv !== 32'hFFFFFFF8) begin n_err++; $display("FAIL bl_bv got %h exp FFFFFFF8", dec_bv); end
    tick();
  endtask

  task automatic test_hazard(input logic [31:0] second, input logic bubble);
    dec_ready = 1'b1;
    push(32'hE5914000, 32'h500);
    tick();
    push(second, 32'h504);
    tick();
    fetch_valid = 1'b0;
    n_vec++; if (dec_valid !== 1'b1 || dec_is_load !== 1'b1 || dec_rd !== 4'd4 || dec_uses_rm !== 1'b0 || dec_mem_we !== 1'b0) begin
      n_err++; $display("FAIL ld_dec got v %b ld %b rd %0d rm %b mw %b exp 1 1 4 0 0", dec_valid, dec_is_load, dec_rd, dec_uses_rm, dec_mem_we); end
    tick();
    if (bubble) begin
      n_vec++; if (dec_valid !== 1'b0 || q_count !== 3'd1) begin
        n_err++; $display("FAIL hz_bubble got v %b cnt %0d exp 0/1", dec_valid, q_count); end
      tick();
    end
    n_vec++; if (dec_valid !== 1'b1 || dec_pc !== 32'h504) begin
      n_err++; $display("FAIL hz_next got v %b pc %h exp 1/504 (bubble=%b)", dec_valid, dec_pc, bubble); end
    tick();
  endtask

  task automatic test_flush();
    dec_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push(32'hE0800000 | (i << 12), 32'h600 + 4 * i);
      tick();
    end
    n_vec++; if (q_count !== 3'd3 || dec_valid !== 1'b1) begin n_err++; $display("FAIL fl_pre got cnt %0d v %b exp 3/1", q_count, dec_valid); end
    flush = 1'b1;
    push(32'hE0809000, 32'h6F0);
    tick();
    flush = 1'b0; fetch_valid = 1'b0;
    n_vec++; if (dec_valid !== 1'b0 || q_count !== 3'd0) begin n_err++; $display("FAIL fl_clear got v %b cnt %0d exp 0/0", dec_valid, q_count); end
    tick();
    n_vec++; if (dec_valid !== 1'b0 || q_count !== 3'd0) begin n_err++; $display("FAIL fl_drop got v %b cnt %0d exp 0/0", dec_valid, q_count); end
    dec_ready = 1'b1;
    push(32'hE0812003, 32'h700);
    tick();
    fetch_valid = 1'b0;
    tick();
    n_vec++; if (dec_valid !== 1'b1 || dec_pc !== 32'h700) begin n_err++; $display("FAIL fl_after got v %b pc %h exp 1/700", dec_valid, dec_pc); end
    tick();
  endtask

  task automatic test_rst_mid();
    dec_ready = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      push(32'hE0800000 | (i << 12) | i, 32'h800 + 4 * i);
      tick();
    end
    fetch_valid = 1'b0;
    n_vec++; if (fetch_ready !== 1'b0 || q_count !== 3'd4) begin n_err++; $display("FAIL rm_full got fr %b cnt %0d exp 0/4", fetch_ready, q_count); end
    rst = 1'b1;
    tick();
    n_vec++; if (dec_valid !== 1'b0 || q_count !== 3'd0 || fetch_ready !== 1'b0) begin
      n_err++; $display("FAIL rm_ctl got v %b cnt %0d fr %b exp 0 0 0", dec_valid, q_count, fetch_ready); end
    n_vec++; if (dec_pc !== 32'h0 || dec_alu_op !== 4'h0 || dec_reg_we !== 1'b0 || dec_bv !== 32'h0) begin
      n_err++; $display("FAIL rm_zero got pc %h op %0d we %b bv %h exp all 0", dec_pc, dec_alu_op, dec_reg_we, dec_bv); end
    rst = 1'b0;
    dec_ready = 1'b1;
    push(32'hE0845006, 32'h900);
    tick();
    fetch_valid = 1'b0;
    tick();
    n_vec++; if (dec_valid !== 1'b1 || dec_pc !== 32'h900 || dec_rn !== 4'd4 || dec_rd !== 4'd5 || dec_rm !== 4'd6) begin
      n_err++; $display("FAIL rm_fresh got v %b pc %h rn %0d rd %0d rm %0d exp 1 900 4 5 6", dec_valid, dec_pc, dec_rn, dec_rd, dec_rm); end
    tick();
  endtask

  initial begin
    test_reset();
    test_data();
    test_full();
    test_branch();
    test_hazard(32'hE0845006, 1'b1);
    test_hazard(32'hE0875006, 1'b0);
    test_flush();
    test_rst_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
